// File: rtl/serial_parity_checker_if.sv
// Receive-side bundle for the even-parity serial link.
// Carries err_count only when PARITY_ERR_CNT_EN is defined.
interface serial_parity_checker_if #(
  parameter int DATA_W = 3
);
  logic              bit_en;
  logic              serial_in;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;
`ifdef PARITY_ERR_CNT_EN
  logic [7:0]        err_count;

  modport master (
    output bit_en, serial_in, rx_ready,
    input  rx_data, rx_valid, parity_err,
    input  frame_err, overrun, err_count
  );

  modport slave (
    input  bit_en, serial_in, rx_ready,
    output rx_data, rx_valid, parity_err,
    output frame_err, overrun, err_count
  );
`else
  modport master (
    output bit_en, serial_in, rx_ready,
    input  rx_data, rx_valid, parity_err,
    input  frame_err, overrun
  );

  modport slave (
    input  bit_en, serial_in, rx_ready,
    output rx_data, rx_valid, parity_err,
    output frame_err, overrun
  );
`endif
endinterface

// File: rtl/serial_parity_checker.sv
// Even-parity serial frame receiver with valid/ready output slot.
// PARITY_ERR_CNT_EN adds a saturating parity-error counter.
module serial_parity_checker #(
  parameter int DATA_W = 3
) (
  input logic               clk,
  input logic               rst,
  serial_parity_checker_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              done;
  logic              load;
  logic              perr_new;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    data_d   = data_q;
    valid_d  = valid_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    ovr_d    = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    perr_new = (^shift_q) ^ par_q;

    if (bus.bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.serial_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          // LSB-first: first line bit ends up in bit 0
          for (int i = 0; i < DATA_W - 1; i++) begin
            shift_d[i] = shift_q[i+1];
          end
          shift_d[DATA_W-1] = bus.serial_in;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = bus.serial_in;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          done    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (done && (!valid_q || bus.rx_ready)) begin
      load    = 1'b1;
      data_d  = shift_q;
      perr_d  = perr_new;
      ferr_d  = !bus.serial_in;
      valid_d = 1'b1;
    end else if (done) begin
      ovr_d = 1'b1;
    end else if (valid_q && bus.rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (load && perr_new && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 8'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_count = err_q;
`else
  logic unused_load;
  assign unused_load = load;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench for serial_parity_checker (DATA_W=3).
// Checks err_count too when PARITY_ERR_CNT_EN is defined.
module tb_serial_parity_checker;

  logic clk;
  logic rst;

  serial_parity_checker_if #(.DATA_W(3)) bus ();

  serial_parity_checker #(.DATA_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b, input int gap,
                          input logic rdy);
    bus.bit_en    = 1'b1;
    bus.serial_in = b;
    bus.rx_ready  = rdy;
    @(negedge clk);
    bus.bit_en    = 1'b0;
    bus.serial_in = 1'b1;
    bus.rx_ready  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [2:0] d, input logic p,
                            input logic s, input int gap,
                            input logic rdy_stop,
                            input logic deliver);
    exp_t e;
    if (deliver) begin
      e.d  = d;
      e.pe = d[0] ^ d[1] ^ d[2] ^ p;
      e.fe = !s;
      sb.push_back(e);
      if (e.pe && exp_err != 255) exp_err++;
    end
    send_bit(1'b0, gap, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i], gap, 1'b0);
    send_bit(p, gap, 1'b0);
    send_bit(s, 0, rdy_stop);
  endtask

  task automatic check_out(input string name);
    exp_t e;
    tests++;
    if (bus.rx_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s valid: got %b want 1", name, bus.rx_valid);
    end
    tests++;
    if (bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL %s overrun: got %b want 0", name, bus.overrun);
    end
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard: got empty want entry", name);
      return;
    end
    e = sb.pop_front();
    tests++;
    if (bus.rx_data !== e.d) begin
      fails++;
      $display("FAIL %s data: got %b want %b", name, bus.rx_data, e.d);
    end
    tests++;
    if (bus.parity_err !== e.pe) begin
      fails++;
      $display("FAIL %s parity_err: got %b want %b",
               name, bus.parity_err, e.pe);
    end
    tests++;
    if (bus.frame_err !== e.fe) begin
      fails++;
      $display("FAIL %s frame_err: got %b want %b",
               name, bus.frame_err, e.fe);
    end
`ifdef PARITY_ERR_CNT_EN
    tests++;
    if (bus.err_count !== 8'(exp_err)) begin
      fails++;
      $display("FAIL %s err_count: got %0d want %0d",
               name, bus.err_count, exp_err);
    end
`endif
  endtask

  task automatic accept(input string name);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    tests++;
    if (bus.rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s accept: got valid %b want 0",
               name, bus.rx_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.rx_valid, bus.rx_data, bus.parity_err,
         bus.frame_err, bus.overrun} !== 7'b0) begin
      fails++;
      $display("FAIL reset outs: got v=%b d=%b pe=%b fe=%b ov=%b want 0",
               bus.rx_valid, bus.rx_data, bus.parity_err,
               bus.frame_err, bus.overrun);
    end
`ifdef PARITY_ERR_CNT_EN
    tests++;
    if (bus.err_count !== 8'd0) begin
      fails++;
      $display("FAIL reset err_count: got %0d want 0", bus.err_count);
    end
`endif
  endtask

  task automatic test_good();
    send_frame(3'b101, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    check_out("good");
    accept("good");
  endtask

  task automatic test_parity_err();
    send_frame(3'b111, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    check_out("perr");
    accept("perr");
  endtask

  task automatic test_frame_err();
    send_frame(3'b100, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    check_out("ferr");
    accept("ferr");
  endtask

  task automatic test_overrun();
    send_frame(3'b101, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    check_out("ovr_first");
    send_frame(3'b011, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    tests++;
    if (bus.overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_pulse: got %b want 1", bus.overrun);
    end
    tests++;
    if (bus.rx_data !== 3'b101 || bus.rx_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovr_hold: got v=%b d=%b want v=1 d=101",
               bus.rx_valid, bus.rx_data);
    end
    @(negedge clk);
    tests++;
    if (bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL ovr_width: got %b want 0", bus.overrun);
    end
    tests++;
    if (bus.rx_data !== 3'b101) begin
      fails++;
      $display("FAIL ovr_hold2: got %b want 101", bus.rx_data);
    end
    send_frame(3'b011, 1'b0, 1'b1, 0, 1'b1, 1'b1);
    check_out("ovr_reload");
    accept("ovr_reload");
  endtask

  task automatic test_bit_en_gap();
    send_frame(3'b110, 1'b0, 1'b1, 2, 1'b0, 1'b1);
    check_out("gap");
  endtask

  task automatic test_reset_mid();
    send_bit(1'b0, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_err = 0;
    tests++;
    if (bus.rx_valid !== 1'b0 || bus.rx_data !== 3'b000 ||
        bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid clear: got v=%b d=%b ov=%b want 0",
               bus.rx_valid, bus.rx_data, bus.overrun);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (bus.rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid partial: got valid %b want 0",
               bus.rx_valid);
    end
    send_frame(3'b001, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    check_out("rst_mid");
    accept("rst_mid");
  endtask

  initial begin
    rst           = 1'b1;
    bus.bit_en    = 1'b0;
    bus.serial_in = 1'b1;
    bus.rx_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_good();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_bit_en_gap();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL leftover: got %0d entries want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
